// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem request/grant/response bus, decode valid/ready handshake and redirect
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, imem request/response tracking, stale-response drop and decode FIFO
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   pc_q, resp_pc, tgt;
  logic [CW-1:0] inflight, drop, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];
  logic          pop, gnt, take, stale, push;
  int            used;
  // A pop this cycle frees its slot before any response to a new grant can land,
  // so it is credited immediately; this keeps one instruction per cycle at DEPTH=2.
  always_comb begin
    tgt = {bus.redirect_pc[31:2], 2'b00};
    bus.instr_valid = count != '0;
    pop = bus.instr_valid & bus.instr_ready;
    used = int'(count) + int'(inflight) + int'(drop) - int'(pop);
    bus.imem_req = rst_n & !bus.redirect_valid & (used < DEPTH);
    bus.imem_addr = pc_q;
    bus.instr = bus.instr_valid ? fifo_instr[rd_ptr] : '0;
    bus.instr_pc = bus.instr_valid ? fifo_pc[rd_ptr] : '0;
    gnt = bus.imem_req & bus.imem_gnt;
    stale = bus.imem_rvalid & (drop != '0);
    take = bus.imem_rvalid & (drop == '0) & (inflight != '0);
    push = take & !bus.redirect_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= RESET_PC;
      resp_pc <= RESET_PC;
      inflight <= '0;
      drop <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect_valid) begin
      pc_q <= tgt;
      resp_pc <= tgt;
      inflight <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      drop <= drop + inflight - CW'(stale | take);
    end else begin
      if (gnt) pc_q <= pc_q + 32'd4;
      if (push) resp_pc <= resp_pc + 32'd4;
      inflight <= inflight + CW'(gnt) - CW'(take);
      drop <= drop - CW'(stale);
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  always_ff @(posedge clk)
    if (push) begin
      fifo_instr[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr] <= resp_pc;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven startup/stall vectors plus redirect, wrap and async-reset sequences
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rsp_en = 1'b1;
  logic rv;
  logic [31:0] rdat;
  logic [31:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  instr_fetch_if bus();
  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [31:0] d(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F1E_2D3C;
  endfunction
  assign bus.imem_gnt = bus.imem_req;
  assign bus.imem_rvalid = rv;
  assign bus.imem_rdata = rdat;
  // In-order memory: a grant at edge E responds at edge E+1 unless rsp_en holds it back.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      rv <= 1'b0;
      rdat <= '0;
    end else begin
      if (bus.imem_req && bus.imem_gnt) q.push_back(bus.imem_addr);
      if (rsp_en && q.size() > 0) begin
        rv <= 1'b1;
        rdat <= d(q[0]);
        void'(q.pop_front());
      end else rv <= 1'b0;
    end
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk(input string nm, input logic ev, input logic [31:0] epc, input logic ereq, input logic [31:0] eaddr);
    cmp({nm, " valid"}, 32'(bus.instr_valid), 32'(ev));
    cmp({nm, " pc"}, bus.instr_pc, ev ? epc : 32'h0);
    cmp({nm, " instr"}, bus.instr, ev ? d(epc) : 32'h0);
    cmp({nm, " req"}, 32'(bus.imem_req), 32'(ereq));
    cmp({nm, " addr"}, bus.imem_addr, eaddr);
  endtask
  task automatic step(input string nm, input logic ev, input logic [31:0] epc, input logic ereq, input logic [31:0] eaddr);
    @(negedge clk);
    chk(nm, ev, epc, ereq, eaddr);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b1;
    rsp_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  typedef struct {
    logic        ready;
    logic        ev;
    logic [31:0] epc;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;
  function automatic vec_t mk(input logic r, input logic ev, input logic [31:0] pc, input logic rq, input logic [31:0] a);
    vec_t v;
    v.ready = r;
    v.ev = ev;
    v.epc = pc;
    v.ereq = rq;
    v.eaddr = a;
    return v;
  endfunction
  vec_t tv[14];
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0]  = mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h00);
    tv[1]  = mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h04);
    tv[2]  = mk(1'b1, 1'b1, 32'h00, 1'b1, 32'h08);
    tv[3]  = mk(1'b1, 1'b1, 32'h04, 1'b1, 32'h0C);
    tv[4]  = mk(1'b1, 1'b1, 32'h08, 1'b1, 32'h10);
    tv[5]  = mk(1'b0, 1'b1, 32'h0C, 1'b0, 32'h14);
    tv[6]  = mk(1'b0, 1'b1, 32'h0C, 1'b0, 32'h14);
    tv[7]  = mk(1'b0, 1'b1, 32'h0C, 1'b0, 32'h14);
    tv[8]  = mk(1'b0, 1'b1, 32'h0C, 1'b0, 32'h14);
    tv[9]  = mk(1'b0, 1'b1, 32'h0C, 1'b0, 32'h14);
    tv[10] = mk(1'b1, 1'b1, 32'h0C, 1'b1, 32'h14);
    tv[11] = mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h18);
    tv[12] = mk(1'b1, 1'b1, 32'h14, 1'b1, 32'h1C);
    tv[13] = mk(1'b1, 1'b1, 32'h18, 1'b1, 32'h20);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;
    #2;
    chk("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.instr_ready = tv[i].ready;
      step($sformatf("vec%0d", i), tv[i].ev, tv[i].epc, tv[i].ereq, tv[i].eaddr);
    end
    do_reset();
    rsp_en = 1'b0;
    step("rd c0", 1'b0, 32'h0, 1'b1, 32'h0);
    step("rd c1", 1'b0, 32'h0, 1'b1, 32'h4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    step("rd c2", 1'b0, 32'h0, 1'b0, 32'h8);
    bus.redirect_valid = 1'b0;
    rsp_en = 1'b1;
    step("rd c3", 1'b0, 32'h0, 1'b0, 32'h100);
    step("rd c4", 1'b0, 32'h0, 1'b0, 32'h100);
    step("rd c5", 1'b0, 32'h0, 1'b1, 32'h100);
    step("rd c6", 1'b0, 32'h0, 1'b1, 32'h104);
    step("rd c7", 1'b1, 32'h100, 1'b1, 32'h108);
    do_reset();
    step("rp c0", 1'b0, 32'h0, 1'b1, 32'h0);
    step("rp c1", 1'b0, 32'h0, 1'b1, 32'h4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step("rp c2", 1'b1, 32'h0, 1'b0, 32'h8);
    bus.redirect_valid = 1'b0;
    step("rp c3", 1'b0, 32'h0, 1'b1, 32'h200);
    step("rp c4", 1'b0, 32'h0, 1'b1, 32'h204);
    step("rp c5", 1'b1, 32'h200, 1'b1, 32'h208);
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    step("wr c0", 1'b0, 32'h0, 1'b0, 32'h0);
    bus.redirect_valid = 1'b0;
    step("wr c1", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
    step("wr c2", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    step("wr c3", 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0);
    step("wr c4", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h4);
    step("wr c5", 1'b1, 32'h0, 1'b1, 32'h8);
    do_reset();
    step("rs c0", 1'b0, 32'h0, 1'b1, 32'h0);
    step("rs c1", 1'b0, 32'h0, 1'b1, 32'h4);
    step("rs c2", 1'b1, 32'h0, 1'b1, 32'h8);
    step("rs c3", 1'b1, 32'h4, 1'b1, 32'hC);
    chk("rs pre", 1'b1, 32'h8, 1'b1, 32'h10);
    rst_n = 1'b0;
    #1;
    chk("rs async", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rs r0", 1'b0, 32'h0, 1'b1, 32'h0);
    step("rs r1", 1'b0, 32'h0, 1'b1, 32'h4);
    step("rs r2", 1'b1, 32'h0, 1'b1, 32'h8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
